delay_timer: RTL and testbench
==============================

DELAY_TIMER -- requirements
Module: delay_timer

Interface
REQ-001 SHALL have ports: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: trigger  input  1  timer trigger, sampled on rising clk.
REQ-004 SHALL have ports: mode  input  2  operating mode (00 one-shot, 01 retriggerable one-shot, 10 delay-on, 11 delay-off).
REQ-005 SHALL have ports: weight  input  8  delay/pulse length in clk cycles, unsigned 0..255.
REQ-006 SHALL have ports: out  output  1  timer output, driven directly from a flip-flop.

Function
REQ-007 SHALL register trigger into trig_q each cycle; a rising edge is trigger=1 and trig_q=0 at a clk edge.
REQ-008 SHALL keep an 8-bit down-counter; it never wraps below 0 and never exceeds the loaded weight.
REQ-009 Mode 00: a rising edge at clk edge k SHALL set out=1 after edge k and clear it after edge k+weight (pulse exactly weight cycles); edges while out=1 SHALL be ignored.
REQ-010 Mode 01: same as mode 00, except a rising edge while out=1 SHALL reload the counter, so out clears weight cycles after the latest edge.
REQ-011 Modes 00/01, weight=0: a rising edge SHALL produce no pulse (out stays 0).
REQ-012 Mode 10: out SHALL go 1 after edge k+weight, where trigger was first sampled 1 at edge k and stayed 1 through k+weight; out=1 after edge k when weight=0.
REQ-013 Mode 10: trigger sampled 0 SHALL clear out and the counter after that edge, including a pulse shorter than weight.
REQ-014 Mode 11: trigger sampled 1 SHALL set out=1 after that edge; when trigger is first sampled 0 at edge j, out SHALL clear after edge j+weight (after edge j when weight=0).
REQ-015 Mode 11: trigger sampled 1 during the off-delay SHALL cancel the countdown and keep out=1.
REQ-016 weight SHALL be sampled only when the counter is loaded; changes mid-count SHALL not affect the running count.
REQ-017 A change of mode (mode differs from its registered copy) SHALL clear out and the counter on that edge; the new mode then starts from idle.

Reset
REQ-018 reset=0 SHALL immediately force out=0, counter=0, trig_q=0 and the registered mode copy to the current mode value, independent of clk.
REQ-019 After reset release, trigger=1 at the first clk edge SHALL count as a rising edge.
REQ-020 reset asserted mid-pulse or mid-delay SHALL abort the operation with no residual output.

Structure
REQ-021 A shared package SHALL hold the 2-bit mode constants (MODE_ONESHOT, MODE_RETRIG, MODE_DELAY_ON, MODE_DELAY_OFF) and the counter width constant (8).
REQ-022 One sub-module SHALL be used: trig_edge_detect, which provides registered trigger and a rising-edge pulse, with the same clk/reset.
REQ-023 The rest of the block SHALL be a single always block for the counter/out plus combinational next-state logic.

Verification
REQ-024 Mode 11, weight=3, trigger high for 12 cycles then low -> out=1 one edge after the first high sample, held, clears exactly 3 edges after the first low sample.
REQ-025 Mode 11, weight=3, trigger low 2 cycles then high again -> out never drops.
REQ-026 Mode 00, weight=5, two rising edges 2 cycles apart -> one 5-cycle pulse; mode 01, same stimulus -> a 7-cycle pulse.
REQ-027 Mode 10, weight=4: trigger high 3 cycles -> out stays 0; trigger high 10 cycles -> out=1 from edge k+4 until the edge after trigger falls.
REQ-028 Mode 00/01 with weight=0 -> out stays 0; mode 10/11 with weight=0 -> out tracks sampled trigger with 1-cycle latency.
REQ-029 Assert reset=0 asynchronously mid-pulse (mode 00, weight=10) -> out=0 immediately; mode change mid-delay -> out=0 on the next edge.

Source files
------------

// File: rtl/delay_timer_pkg.sv
// Shared constants for the delay timer: operating mode encodings and counter width.
package delay_timer_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] MODE_ONESHOT   = 2'b00;
    localparam logic [1:0] MODE_RETRIG    = 2'b01;
    localparam logic [1:0] MODE_DELAY_ON  = 2'b10;
    localparam logic [1:0] MODE_DELAY_OFF = 2'b11;

endpackage

// File: rtl/trig_edge_detect.sv
// Registers the trigger input and flags a rising edge (trigger high while last sample low).
module trig_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    output logic trig_q,
    output logic rise
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trigger;
        end
    end

    assign rise = trigger & ~trig_q;

endmodule

// File: rtl/delay_timer.sv
// Programmable timer: one-shot, retriggerable one-shot, on-delay and off-delay modes
// built around an 8-bit down-counter that only samples weight when it loads.
module delay_timer
    import delay_timer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] weight,
    output logic             out
);

    logic             trig_q;
    logic             rise;
    logic [1:0]       mode_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             out_reg, out_next;

    trig_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .trigger (trigger),
        .trig_q  (trig_q),
        .rise    (rise)
    );

    always_comb begin
        out_next = out_reg;
        cnt_next = cnt_reg;
        if (mode != mode_reg) begin
            // New mode always starts from idle.
            out_next = 1'b0;
            cnt_next = '0;
        end else begin
            case (mode)
                MODE_ONESHOT, MODE_RETRIG: begin
                    if (rise && (!out_reg || mode == MODE_RETRIG)) begin
                        cnt_next = weight;
                        out_next = (weight != '0);
                    end else if (out_reg) begin
                        if (cnt_reg <= CNT_W'(1)) begin
                            out_next = 1'b0;
                            cnt_next = '0;
                        end else begin
                            cnt_next = cnt_reg - CNT_W'(1);
                        end
                    end
                end
                MODE_DELAY_ON: begin
                    if (!trigger) begin
                        out_next = 1'b0;
                        cnt_next = '0;
                    end else if (!out_reg) begin
                        if (cnt_reg == '0) begin
                            // Idle with trigger high: start the on-delay.
                            if (weight == '0) out_next = 1'b1;
                            else              cnt_next = weight;
                        end else if (cnt_reg == CNT_W'(1)) begin
                            out_next = 1'b1;
                            cnt_next = '0;
                        end else begin
                            cnt_next = cnt_reg - CNT_W'(1);
                        end
                    end
                end
                MODE_DELAY_OFF: begin
                    if (trigger) begin
                        out_next = 1'b1;
                        cnt_next = '0;
                    end else if (cnt_reg != '0) begin
                        if (cnt_reg == CNT_W'(1)) begin
                            out_next = 1'b0;
                            cnt_next = '0;
                        end else begin
                            cnt_next = cnt_reg - CNT_W'(1);
                        end
                    end else if (out_reg && trig_q) begin
                        // First low sample after high: load the off-delay.
                        if (weight == '0) out_next = 1'b0;
                        else              cnt_next = weight;
                    end
                end
                default: begin
                    out_next = 1'b0;
                    cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg  <= 1'b0;
            cnt_reg  <= '0;
            mode_reg <= mode;
        end else begin
            out_reg  <= out_next;
            cnt_reg  <= cnt_next;
            mode_reg <= mode;
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer: per-cycle output waveforms checked against hand-derived vectors.
module tb_delay_timer;
    import delay_timer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic [1:0] mode = MODE_ONESHOT;
    logic [7:0] weight = 8'd0;
    logic       out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    delay_timer dut (
        .clk     (clk),
        .reset   (reset),
        .trigger (trigger),
        .mode    (mode),
        .weight  (weight),
        .out     (out)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; reset pulse completes before the next edge.
    task automatic do_reset(input logic [1:0] m, input logic [7:0] w);
        mode    = m;
        weight  = w;
        trigger = 1'b0;
        reset   = 1'b0;
        #2;
        check("reset out", {7'd0, out}, 8'd0);
        reset = 1'b1;
    endtask

    // Bit i of trig is driven before edge i; bit i of exp is out after edge i.
    task automatic run(input string tag, input logic [1:0] m, input logic [7:0] w,
                       input logic [31:0] trig, input logic [31:0] exp, input int n,
                       input int wchg_at = -1, input logic [7:0] w2 = 8'd0);
        do_reset(m, w);
        for (int i = 0; i < n; i++) begin
            if (i == wchg_at) weight = w2;
            trigger = trig[i];
            tick();
            check($sformatf("%s step %0d", tag, i), {7'd0, out}, {7'd0, exp[i]});
        end
        trigger = 1'b0;
        $display("run %s: mode=%0d weight=%0d steps=%0d", tag, m, w, n);
    endtask

    initial begin
        tick();

        run("off_delay_12hi", MODE_DELAY_OFF, 8'd3, 32'h0000_0FFF, 32'h0000_7FFF, 20);
        run("off_delay_gap",  MODE_DELAY_OFF, 8'd3, 32'h0000_03CF, 32'h0000_1FFF, 16);
        run("oneshot_2edge",  MODE_ONESHOT,   8'd5, 32'h0000_0005, 32'h0000_001F, 12);
        run("retrig_2edge",   MODE_RETRIG,    8'd5, 32'h0000_0005, 32'h0000_007F, 12);
        run("on_delay_short", MODE_DELAY_ON,  8'd4, 32'h0000_0007, 32'h0000_0000, 10);
        run("on_delay_long",  MODE_DELAY_ON,  8'd4, 32'h0000_03FF, 32'h0000_03F0, 14);
        run("oneshot_w0",     MODE_ONESHOT,   8'd0, 32'h0000_0005, 32'h0000_0000, 8);
        run("retrig_w0",      MODE_RETRIG,    8'd0, 32'h0000_0005, 32'h0000_0000, 8);
        run("on_delay_w0",    MODE_DELAY_ON,  8'd0, 32'h0000_006D, 32'h0000_006D, 9);
        run("off_delay_w0",   MODE_DELAY_OFF, 8'd0, 32'h0000_006D, 32'h0000_006D, 9);
        run("oneshot_w1",     MODE_ONESHOT,   8'd1, 32'h0000_0001, 32'h0000_0001, 4);
        run("off_delay_w1",   MODE_DELAY_OFF, 8'd1, 32'h0000_0003, 32'h0000_0007, 6);
        run("oneshot_wchg",   MODE_ONESHOT,   8'd5, 32'h0000_0001, 32'h0000_001F, 8, 2, 8'd2);
        run("retrig_wchg",    MODE_RETRIG,    8'd5, 32'h0000_0009, 32'h0000_001F, 10, 2, 8'd2);

        // Asynchronous reset in the middle of a one-shot pulse.
        do_reset(MODE_ONESHOT, 8'd10);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("pulse live before reset", {7'd0, out}, 8'd1);
        reset = 1'b0;
        #1;
        check("async reset mid-pulse", {7'd0, out}, 8'd0);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("after reset step %0d", i), {7'd0, out}, 8'd0);
        end
        $display("run reset_mid_pulse: mode=0 weight=10");

        // Mode change while an off-delay is counting.
        do_reset(MODE_DELAY_OFF, 8'd5);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
        check("off-delay live", {7'd0, out}, 8'd1);
        mode = MODE_DELAY_ON;
        tick();
        check("mode change clears", {7'd0, out}, 8'd0);
        trigger = 1'b1;
        tick();
        check("new mode idle start", {7'd0, out}, 8'd0);
        trigger = 1'b0;
        $display("run mode_change_mid_delay: mode=3->2 weight=5");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
